// File: rtl/step_drive_guard.sv
// Coil-drive pulse limiter: synchronises NCH drive requests, gates them off after
// TIMEOUT cycles without a fresh rising edge, then enforces a cooldown and records the trip.
module step_drive_guard #(
  parameter int          NCH         = 4,
  parameter int          TMO_W       = 20,
  parameter int unsigned TIMEOUT     = 20'hFFFFF,
  parameter int          COOL_W      = 20,
  parameter int unsigned COOL        = 20'hFFFFF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] drive_in,
  input  logic           fault_clr,
  output logic [NCH-1:0] drive_out,
  output logic           running,
  output logic           fault,
  output logic [7:0]     trip_cnt,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL - 1);

  logic [NCH-1:0]    sync_q [SYNC_STAGES];
  logic [NCH-1:0]    hist_q;
  logic [NCH-1:0]    s;
  logic              rise_any;
  state_e            state_q, state_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              trip;
  logic              fault_q;
  logic [7:0]        trip_q;
  logic [NCH-1:0]    drive_q;
  logic              run_q;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise_any = |(s & ~hist_q);

  // Any channel's rising edge re-arms the shared timer; edge beats expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cool_d  = cool_q;
    trip    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_any && en) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (rise_any) begin
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_COOL;
          cool_d  = '0;
          trip    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_COOL: begin
        if (cool_q == COOL_LAST) state_d = ST_IDLE;
        else                     cool_d  = cool_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        cool_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q  <= '0;
      state_q <= ST_IDLE;
      timer_q <= '0;
      cool_q  <= '0;
      fault_q <= 1'b0;
      trip_q  <= '0;
      drive_q <= '0;
      run_q   <= 1'b0;
    end else begin
      sync_q[0] <= drive_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      // History tracks s even in COOL, so inputs held through cooldown cannot re-arm.
      hist_q  <= s;
      state_q <= state_d;
      timer_q <= timer_d;
      cool_q  <= cool_d;
      if (trip)           fault_q <= 1'b1;
      else if (fault_clr) fault_q <= 1'b0;
      if (trip && (trip_q != 8'hFF)) trip_q <= trip_q + 8'd1;
      drive_q <= (state_d == ST_RUN) ? s : '0;
      run_q   <= (state_d == ST_RUN);
    end
  end

  assign drive_out = drive_q;
  assign running   = run_q;
  assign fault     = fault_q;
  assign trip_cnt  = trip_q;
  assign state     = state_q;

endmodule

// File: doc/step_drive_guard.md
Name: step_drive_guard

Overview:
- Parametrised successor to the fixed 4-channel stepper-coil pulse limiter.
- Gates NCH coil-drive inputs so that no output stays asserted longer than TIMEOUT cycles without a fresh rising edge on some input.
- After a timeout, forces a mandatory cooldown and latches a sticky fault plus a saturating trip counter for housekeeping readout.
- Sits between the step-sequencer registers and the motor-driver pins.

Parameters:
NCH, 4, number of coil channels (>=1)
TMO_W, 20, width of the timeout counter
TIMEOUT, 20'hFFFFF, max drive cycles after the last accepted edge (1..2^TMO_W-1)
COOL_W, 20, width of the cooldown counter
COOL, 20'hFFFFF, forced-off cycles after a trip (1..2^COOL_W-1)
SYNC_STAGES, 2, input synchroniser depth (>=1)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
en  in  1  global drive enable
drive_in  in  NCH  requested coil levels; asynchronous to clk
fault_clr  in  1  one-cycle pulse; clears fault
drive_out  out  NCH  registered, gated coil drive
running  out  1  high while state==RUN
fault  out  1  sticky timeout flag
trip_cnt  out  8  saturating timeout count
state  out  2  0=IDLE, 1=RUN, 2=COOL

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters, synchroniser flops and edge-history flops 0; drive_out=0, running=0, fault=0, trip_cnt=0.
- Synchroniser: each drive_in bit passes through SYNC_STAGES flops, giving s[i]. Edge-history register h <= s every cycle, in all states.
- Rising edge definition: edge = OR over i of (s[i] & ~h[i]).
- IDLE:
  - edge & en -> RUN, timer<=0.
  - otherwise stay in IDLE.
- RUN:
  - en=0 -> IDLE, timer<=0.
  - else edge -> stay RUN, timer<=0.
  - else timer==TIMEOUT-1 -> COOL, cool<=0, fault<=1, trip_cnt<=sat(trip_cnt+1) (holds at 255).
  - else timer<=timer+1.
- COOL:
  - Edges and en are ignored; the cooldown always completes.
  - cool==COOL-1 -> IDLE; otherwise cool<=cool+1.
  - Inputs held high through COOL do not re-arm on exit. A new rising edge (after h catches up) is required.
- Output: drive_out <= s & {NCH{next_state==RUN}}. running <= (next_state==RUN). Outputs never glitch.
- Latency:
  - A drive_in rise sampled at edge E appears on drive_out at edge E+SYNC_STAGES.
  - A fall is delayed by the same amount.
- Drive duration: from the accepting edge, with no further edges, drive_out stays high exactly TIMEOUT cycles, then falls on the trip edge.
- Edge and expiry on the same cycle: the edge wins; stay RUN with timer<=0.
- fault_clr: fault<=0. If a trip occurs on the same cycle, set wins. trip_cnt is cleared only by reset.
- Channel independence: a rising edge on any one channel re-arms the shared timer for all channels.
- Unused state encoding 3 -> IDLE next cycle with outputs 0.

Test Plan (NCH=4, TIMEOUT=16, COOL=8, SYNC_STAGES=2):
1. rst_n low, then high; drive_in=4'b0000 -> drive_out=0, state=0, fault=0, trip_cnt=0.
2. en=1; drive_in 0000->0001 and held -> drive_out=0001 two edges after first sample, high exactly 16 cycles, then state=2, fault=1, trip_cnt=1; state=0 after 8 cycles; drive_out stays 0 while drive_in remains 0001.
3. Toggle drive_in through 0001,0010,0100,1000 every 10 cycles -> no trip; drive_out tracks drive_in delayed 2 cycles; fault stays 0.
4. Drive a new edge on exactly the cycle timer==15 -> state stays 1, timer restarts, no trip.
5. Trip, then give edges during COOL -> ignored, outputs 0 for all 8 cycles. Drop en mid-RUN -> drive_out 0 next edge. Pulse fault_clr together with a trip -> fault stays 1.
6. 256 consecutive trips -> trip_cnt saturates at 255. rst_n pulsed low mid-RUN -> all outputs 0 immediately.
